// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and frame geometry.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte-side handshake between the UART receiver and its consumer.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic                      rx_ready;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_overrun;
  logic                      frame_err;

  modport master (
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output rx_overrun,
    output frame_err
  );

  modport slave (
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_overrun,
    input  frame_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear and half/full terminal counts.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_done,
  output logic full_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_done = (cnt_q == HalfM1);
  assign full_done = (cnt_q == FullM1);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 LSB-first UART receiver with a one-entry holding register and valid/ready handshake.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_core_if.master rx_if
);
  import uart_pkg::*;

  uart_state_e state_q, state_d;

  logic                      half_done, full_done, tmr_clear;
  logic                      shift_en, byte_done, stop_bad;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shreg_q, data_q;
  logic                      valid_q, overrun_q, ferr_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .half_done(half_done),
    .full_done(full_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StWaitHigh;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWaitHigh: if (rx) state_d = StIdle;
      StIdle:     if (!rx) state_d = StStart;
      StStart:    if (half_done) state_d = rx ? StIdle : StData;
      StData:     if (full_done && bit_q == 3'(UART_DATA_BITS - 1)) state_d = StStop;
      // Leaving at mid stop bit lets back-to-back start edges be caught promptly.
      StStop:     if (full_done) state_d = rx ? StIdle : StWaitHigh;
      default:    state_d = StWaitHigh;
    endcase
  end

  always_comb begin
    tmr_clear = 1'b1;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      StStart: tmr_clear = half_done;
      StData: begin
        tmr_clear = full_done;
        shift_en  = full_done;
      end
      StStop: begin
        tmr_clear = full_done;
        byte_done = full_done & rx;
        stop_bad  = full_done & ~rx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= stop_bad;
      if (state_q == StStart) begin
        bit_q <= '0;
      end else if (shift_en) begin
        bit_q <= bit_q + 3'd1;
      end
      if (shift_en) begin
        shreg_q <= {rx, shreg_q[UART_DATA_BITS-1:1]};
      end
      // A new byte always wins; it only counts as overrun if the old one was not taken.
      if (byte_done) begin
        data_q    <= shreg_q;
        valid_q   <= 1'b1;
        overrun_q <= valid_q & ~rx_if.rx_ready;
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_overrun = overrun_q;
  assign rx_if.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  int   checks = 0;
  int   errors = 0;
  logic valid_pre, ferr_pre, seen;

  uart_rx_core_if rx_if ();

  uart_rx_core #(
    .CLKS_PER_BIT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .rx_if(rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; returns 1 time unit after the stop-sample edge E0+152.
  task automatic frame(input logic [7:0] b, input logic stopb, input logic rdy_stop);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1 rx = b[k];
      repeat (16) @(posedge clk);
    end
    #1 rx = stopb;
    repeat (8) @(posedge clk);
    #1;
    valid_pre      = rx_if.rx_valid;
    ferr_pre       = rx_if.frame_err;
    rx_if.rx_ready = rdy_stop;
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b0;
  endtask

  task automatic accept();
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b0;
  endtask

  initial begin
    rx             = 1'b1;
    rx_if.rx_ready = 1'b0;
    reset          = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", rx_if.rx_data, 8'h00);
    check("rst_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    check("rst_overrun", {7'd0, rx_if.rx_overrun}, 8'd0);
    check("rst_ferr", {7'd0, rx_if.frame_err}, 8'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    // Basic frame, not accepted until later
    frame(8'hA5, 1'b1, 1'b0);
    check("a5_valid_pre", {7'd0, valid_pre}, 8'd0);
    check("a5_valid", {7'd0, rx_if.rx_valid}, 8'd1);
    check("a5_data", rx_if.rx_data, 8'hA5);
    check("a5_ferr", {7'd0, rx_if.frame_err}, 8'd0);
    repeat (7) @(posedge clk);
    #1 check("a5_held", {7'd0, rx_if.rx_valid}, 8'd1);
    accept();
    check("a5_accept_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    check("a5_accept_ovr", {7'd0, rx_if.rx_overrun}, 8'd0);

    // Start glitch rejected, then a good frame
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("glitch_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    frame(8'h3C, 1'b1, 1'b0);
    check("3c_valid_pre", {7'd0, valid_pre}, 8'd0);
    check("3c_valid", {7'd0, rx_if.rx_valid}, 8'd1);
    check("3c_data", rx_if.rx_data, 8'h3C);
    repeat (7) @(posedge clk);
    accept();
    check("3c_accept", {7'd0, rx_if.rx_valid}, 8'd0);

    // Framing error, line stuck low, then recovery
    frame(8'h55, 1'b0, 1'b0);
    check("fe_pre", {7'd0, ferr_pre}, 8'd0);
    check("fe_pulse", {7'd0, rx_if.frame_err}, 8'd1);
    check("fe_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    @(posedge clk);
    #1 check("fe_one_cycle", {7'd0, rx_if.frame_err}, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 seen = seen | rx_if.rx_valid | rx_if.frame_err;
    end
    check("fe_low_quiet", {7'd0, seen}, 8'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    frame(8'h0F, 1'b1, 1'b0);
    check("0f_valid", {7'd0, rx_if.rx_valid}, 8'd1);
    check("0f_data", rx_if.rx_data, 8'h0F);
    check("0f_ferr", {7'd0, rx_if.frame_err}, 8'd0);
    repeat (7) @(posedge clk);
    accept();

    // Overrun
    frame(8'h11, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    frame(8'h22, 1'b1, 1'b0);
    check("ovr_valid_pre", {7'd0, valid_pre}, 8'd1);
    check("ovr_data", rx_if.rx_data, 8'h22);
    check("ovr_valid", {7'd0, rx_if.rx_valid}, 8'd1);
    check("ovr_flag", {7'd0, rx_if.rx_overrun}, 8'd1);
    repeat (7) @(posedge clk);
    accept();
    check("ovr_clr_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    check("ovr_clr_flag", {7'd0, rx_if.rx_overrun}, 8'd0);

    // Acceptance on the same edge as a new byte clears overrun
    frame(8'h11, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    frame(8'h33, 1'b1, 1'b0);
    check("same_ovr_before", {7'd0, rx_if.rx_overrun}, 8'd1);
    repeat (7) @(posedge clk);
    frame(8'h22, 1'b1, 1'b1);
    check("same_data", rx_if.rx_data, 8'h22);
    check("same_valid", {7'd0, rx_if.rx_valid}, 8'd1);
    check("same_ovr", {7'd0, rx_if.rx_overrun}, 8'd0);
    repeat (7) @(posedge clk);
    accept();
    check("same_accept", {7'd0, rx_if.rx_valid}, 8'd0);

    // Asynchronous reset mid-frame with outputs non-zero
    frame(8'h5A, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    frame(8'h96, 1'b1, 1'b0);
    check("pre_rst_data", rx_if.rx_data, 8'h96);
    check("pre_rst_ovr", {7'd0, rx_if.rx_overrun}, 8'd1);
    repeat (7) @(posedge clk);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (16 + 48 + 8) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_data", rx_if.rx_data, 8'h00);
    check("mid_rst_valid", {7'd0, rx_if.rx_valid}, 8'd0);
    check("mid_rst_ovr", {7'd0, rx_if.rx_overrun}, 8'd0);
    check("mid_rst_ferr", {7'd0, rx_if.frame_err}, 8'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 seen = seen | rx_if.rx_valid | rx_if.frame_err;
    end
    check("post_rst_quiet", {7'd0, seen}, 8'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    frame(8'hC3, 1'b1, 1'b0);
    check("c3_valid", {7'd0, rx_if.rx_valid}, 8'd1);
    check("c3_data", rx_if.rx_data, 8'hC3);
    check("c3_ovr", {7'd0, rx_if.rx_overrun}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
